// File: rtl/imem_uart_loader.sv
// imem_uart_loader
//   UART boot loader for the instruction memory write port. Receives a framed
//   byte stream (0xA5, word count N, N little-endian 32-bit words) and issues
//   each completed word as a one-cycle write on IMEM_WE/IMEM_A/IMEM_WD.
//
// Ports
//   CLK      in   system clock, rising edge
//   RST_N    in   asynchronous active-low reset
//   RX       in   UART serial input, 8N1, idle high, asynchronous to CLK
//   IMEM_WE  out  one-cycle write strobe
//   IMEM_A   out  byte address (word index << 2)
//   IMEM_WD  out  write data, valid while IMEM_WE is high
//   LOADING  out  frame in progress (hold core in reset, mux address)
//   DONE     out  sticky, last frame completed
//   ERR      out  sticky, last frame aborted
//
// Build option
//   LOADER_CHECKSUM_EN : when defined, a trailing byte equal to the XOR of all
//                        data bytes is required before DONE.
//
// Receiver states
//   RX_IDLE  | waiting for a falling edge on the synchronised line
//   RX_START | timing to mid start bit, rejecting glitches
//   RX_DATA  | sampling 8 data bits LSB first at mid-bit
//   RX_STOP  | sampling stop bit, strobing byte or framing error
//
// Loader states
//   L_IDLE    | waiting for sync byte 0xA5
//   L_SYNC_OK | sync seen, waiting for word count
//   L_DATA    | assembling and writing words
//   L_CSUM    | waiting for checksum byte (checksum build only)
//   L_DONE    | frame completed, DONE held
//   L_ERR     | frame aborted, ERR held
module imem_uart_loader #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DEPTH_WORDS  = 20
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        RX,
    output logic        IMEM_WE,
    output logic [31:0] IMEM_A,
    output logic [31:0] IMEM_WD,
    output logic        LOADING,
    output logic        DONE,
    output logic        ERR
);

    localparam logic [15:0] TMR_FULL = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] TMR_HALF = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]  MAX_N    = 8'(DEPTH_WORDS);
    localparam logic [7:0]  SYNC     = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t   rx_st;
    logic        rx_meta, rx_sync, rx_prev;
    logic [15:0] bit_tmr;
    logic [2:0]  bit_idx;
    logic [7:0]  rx_shift;
    logic        byte_vld, byte_ferr;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            rx_st     <= RX_IDLE;
            bit_tmr   <= '0;
            bit_idx   <= '0;
            rx_shift  <= '0;
            byte_vld  <= 1'b0;
            byte_ferr <= 1'b0;
        end else begin
            rx_meta   <= RX;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            byte_vld  <= 1'b0;
            byte_ferr <= 1'b0;
            case (rx_st)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        bit_tmr <= TMR_HALF;
                        rx_st   <= RX_START;
                    end
                end
                RX_START: begin
                    if (bit_tmr != 16'd0) begin
                        bit_tmr <= bit_tmr - 16'd1;
                    end else if (rx_sync) begin
                        rx_st <= RX_IDLE;   // glitch, not a start bit
                    end else begin
                        bit_tmr <= TMR_FULL;
                        bit_idx <= '0;
                        rx_st   <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (bit_tmr != 16'd0) begin
                        bit_tmr <= bit_tmr - 16'd1;
                    end else begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        bit_tmr  <= TMR_FULL;
                        if (bit_idx == 3'd7) rx_st <= RX_STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end
                end
                RX_STOP: begin
                    if (bit_tmr != 16'd0) begin
                        bit_tmr <= bit_tmr - 16'd1;
                    end else begin
                        rx_st <= RX_IDLE;
                        if (rx_sync) byte_vld  <= 1'b1;
                        else         byte_ferr <= 1'b1;
                    end
                end
                default: rx_st <= RX_IDLE;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {L_IDLE, L_SYNC_OK, L_DATA, L_CSUM, L_DONE, L_ERR} ld_state_t;
`else
    typedef enum logic [2:0] {L_IDLE, L_SYNC_OK, L_DATA, L_DONE, L_ERR} ld_state_t;
`endif

    ld_state_t   ld_st;
    logic [7:0]  n_words;
    logic [7:0]  word_idx;
    logic [1:0]  lane;
    logic [23:0] wd_sr;     // lanes 0..2, newest byte at the top
    logic [7:0]  csum;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ld_st    <= L_IDLE;
            n_words  <= '0;
            word_idx <= '0;
            lane     <= '0;
            wd_sr    <= '0;
            csum     <= '0;
            IMEM_WE  <= 1'b0;
            IMEM_A   <= '0;
            IMEM_WD  <= '0;
            LOADING  <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            IMEM_WE <= 1'b0;
            case (ld_st)
                L_IDLE, L_DONE, L_ERR: begin
                    if (byte_vld && rx_shift == SYNC) begin
                        DONE  <= 1'b0;
                        ERR   <= 1'b0;
                        ld_st <= L_SYNC_OK;
                    end
                end
                L_SYNC_OK: begin
                    if (byte_ferr) begin
                        ERR   <= 1'b1;
                        ld_st <= L_ERR;
                    end else if (byte_vld) begin
                        if (rx_shift != 8'd0 && rx_shift <= MAX_N) begin
                            n_words  <= rx_shift;
                            word_idx <= '0;
                            lane     <= '0;
                            csum     <= '0;
                            LOADING  <= 1'b1;
                            ld_st    <= L_DATA;
                        end else begin
                            ERR   <= 1'b1;
                            ld_st <= L_ERR;
                        end
                    end
                end
                L_DATA: begin
                    if (byte_ferr) begin
                        LOADING <= 1'b0;
                        ERR     <= 1'b1;
                        ld_st   <= L_ERR;
                    end else if (byte_vld) begin
                        lane <= lane + 2'd1;
                        csum <= csum ^ rx_shift;
                        if (lane == 2'd3) begin
                            IMEM_WE  <= 1'b1;
                            IMEM_WD  <= {rx_shift, wd_sr};
                            IMEM_A   <= {22'd0, word_idx, 2'b00};
                            word_idx <= word_idx + 8'd1;
                            if (word_idx == n_words - 8'd1) begin
`ifdef LOADER_CHECKSUM_EN
                                ld_st   <= L_CSUM;
`else
                                LOADING <= 1'b0;
                                DONE    <= 1'b1;
                                ld_st   <= L_DONE;
`endif
                            end
                        end else begin
                            wd_sr <= {rx_shift, wd_sr[23:8]};
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                L_CSUM: begin
                    if (byte_ferr) begin
                        LOADING <= 1'b0;
                        ERR     <= 1'b1;
                        ld_st   <= L_ERR;
                    end else if (byte_vld) begin
                        LOADING <= 1'b0;
                        if (rx_shift == csum) begin
                            DONE  <= 1'b1;
                            ld_st <= L_DONE;
                        end else begin
                            ERR   <= 1'b1;
                            ld_st <= L_ERR;
                        end
                    end
                end
`endif
                default: ld_st <= L_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_uart_loader.sv
// tb_imem_uart_loader
//   Drives UART frames into imem_uart_loader and compares captured writes and
//   status flags against a frame-level model of the expected outcome.
module tb_imem_uart_loader;

    localparam int CPB   = 10;
    localparam int DEPTH = 20;

    logic        CLK   = 1'b0;
    logic        RST_N = 1'b0;
    logic        RX    = 1'b1;
    logic        IMEM_WE;
    logic [31:0] IMEM_A;
    logic [31:0] IMEM_WD;
    logic        LOADING, DONE, ERR;

    imem_uart_loader #(.CLKS_PER_BIT(CPB), .DEPTH_WORDS(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .RX(RX),
        .IMEM_WE(IMEM_WE), .IMEM_A(IMEM_A), .IMEM_WD(IMEM_WD),
        .LOADING(LOADING), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // write capture
    typedef struct packed {logic [31:0] a; logic [31:0] d;} wr_t;
    wr_t  got_q[$];
    int   we_long = 0;
    logic we_last = 1'b0;

    always @(negedge CLK) begin
        if (IMEM_WE === 1'b1) got_q.push_back({IMEM_A, IMEM_WD});
        if (IMEM_WE === 1'b1 && we_last) we_long++;
        we_last = (IMEM_WE === 1'b1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_bit(input logic b);
        RX = b;
        repeat (CPB) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        RX = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
    endtask

    logic [31:0] fwords[$];

    function automatic logic [7:0] xor_words();
        logic [7:0] x = 8'd0;
        foreach (fwords[i]) x = x ^ fwords[i][7:0] ^ fwords[i][15:8]
                                  ^ fwords[i][23:16] ^ fwords[i][31:24];
        return x;
    endfunction

    task automatic fill_rand(input int n);
        fwords.delete();
        for (int i = 0; i < n; i++) fwords.push_back($urandom);
    endtask

    task automatic check_writes(input string tag, input int nexp);
        check({tag, ".nwr"}, 32'(got_q.size()), 32'(nexp));
        for (int i = 0; i < nexp && i < got_q.size(); i++) begin
            check($sformatf("%s.a%0d", tag, i), got_q[i].a, 32'(4 * i));
            check($sformatf("%s.d%0d", tag, i), got_q[i].d, fwords[i]);
        end
        check({tag, ".we1cyc"}, 32'(we_long), 32'd0);
    endtask

    // Full frame with count n and the words in fwords. cs_force overrides the
    // checksum byte with cs_val (checksum build only).
    task automatic run_frame(input string tag, input int n, input bit cs_force, input logic [7:0] cs_val);
        bit         n_ok;
        bit         exp_done;
        logic [7:0] cs;
        got_q.delete();
        we_long  = 0;
        n_ok     = (n >= 1 && n <= DEPTH);
        cs       = xor_words();
        exp_done = n_ok;
`ifdef LOADER_CHECKSUM_EN
        if (cs_force && cs_val != cs) exp_done = 1'b0;
        if (cs_force) cs = cs_val;
`endif
        send_byte(8'hA5, 1'b1);
        send_byte(8'(n), 1'b1);
        idle(CPB);
        check({tag, ".loading"}, 32'(LOADING), 32'(n_ok));
        if (n_ok) begin
            for (int i = 0; i < n; i++) send_word(fwords[i]);
`ifdef LOADER_CHECKSUM_EN
            send_byte(cs, 1'b1);
`endif
        end
        idle(2 * CPB);
        check_writes(tag, n_ok ? n : 0);
        check({tag, ".done"},    32'(DONE),    32'(exp_done));
        check({tag, ".err"},     32'(ERR),     32'(!exp_done));
        check({tag, ".loading_end"}, 32'(LOADING), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".we"},      32'(IMEM_WE), 32'd0);
        check({tag, ".a"},       IMEM_A,       32'd0);
        check({tag, ".wd"},      IMEM_WD,      32'd0);
        check({tag, ".loading"}, 32'(LOADING), 32'd0);
        check({tag, ".done"},    32'(DONE),    32'd0);
        check({tag, ".err"},     32'(ERR),     32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        idle(3);
        check_all_zero("reset");
        RST_N = 1'b1;
        idle(2 * CPB);
        check_all_zero("post_reset");

        // two-word load
        fwords.delete();
        fwords.push_back(32'h00000013);
        fwords.push_back(32'h005000B3);
        run_frame("two_word", 2, 1'b0, 8'd0);

        // bad counts and count boundaries
        run_frame("n_zero", 0, 1'b0, 8'd0);
        run_frame("n_21", DEPTH + 1, 1'b0, 8'd0);
        fill_rand(1);
        run_frame("n_one", 1, 1'b0, 8'd0);
        fill_rand(DEPTH);
        run_frame("n_max", DEPTH, 1'b0, 8'd0);

        // noise before sync: non-sync bytes and a short glitch
        got_q.delete();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        RX = 1'b0;
        idle(3);
        RX = 1'b1;
        idle(2 * CPB);
        check("noise.nwr",  32'(got_q.size()), 32'd0);
        check("noise.done", 32'(DONE), 32'd1);
        fill_rand(1);
        run_frame("after_noise", 1, 1'b0, 8'd0);

        // framing error mid-word
        got_q.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b0);
        idle(2 * CPB);
        check("ferr.nwr",     32'(got_q.size()), 32'd0);
        check("ferr.err",     32'(ERR), 32'd1);
        check("ferr.done",    32'(DONE), 32'd0);
        check("ferr.loading", 32'(LOADING), 32'd0);
        fill_rand(1);
        run_frame("ferr_recover", 1, 1'b0, 8'd0);

        // reset after 3 data bytes
        got_q.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
        check("rst_mid.loading_pre", 32'(LOADING), 32'd1);
        RST_N = 1'b0;
        #1;
        check_all_zero("rst_mid");
        idle(3);
        RST_N = 1'b1;
        idle(2 * CPB);
        check("rst_mid.nwr", 32'(got_q.size()), 32'd0);
        fill_rand(3);
        run_frame("after_rst", 3, 1'b0, 8'd0);

`ifdef LOADER_CHECKSUM_EN
        fwords.delete();
        fwords.push_back(32'h44332211);
        run_frame("csum_bad", 1, 1'b1, 8'h00);
        run_frame("csum_good", 1, 1'b1, 8'h44);
`endif

        // randomized frames
        for (int t = 0; t < 8; t++) begin
            case ($urandom_range(0, 7))
                0:       n = 0;
                1:       n = DEPTH + 1 + int'($urandom_range(0, 10));
                default: n = int'($urandom_range(1, 6));
            endcase
            fill_rand((n >= 1 && n <= DEPTH) ? n : 0);
            run_frame($sformatf("rand%0d", t), n, ($urandom_range(0, 3) == 0),
                      8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
